// File: rtl/hdc_pkg.sv
// Shared HDC definitions: sequencer state encoding and the default bus
// widths common to the sequencer, encoder and classifier.
package hdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    PRESENT   = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_e;

  localparam int unsigned LABEL_W_DEF    = 2;
  localparam int unsigned MAX_LENGTH_DEF = 200;

endpackage

// File: rtl/hdc_score_counter.sv
// Saturating score counter with synchronous clear and increment enable.
// Ports: clk, rst_n (async active-low), clr, inc, cnt (registered count).
module hdc_score_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hdc_msg_sequencer.sv
// Streams messages from the external MSG/LENGTH/TAG ROMs into the HDC
// classifier with a valid/ready handshake, waits for each classification and
// scores the prediction against the ROM label.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   start, loop_mode, abort      run control (loop_mode sampled at start)
//   rom_addr                     shared ROM address (registered)
//   rom_msg, rom_len, rom_label  ROM read data, valid ROM_LAT cycles after addr
//   msg, length, label           registered message payload to classifier
//   msg_valid, msg_ready         payload handshake
//   compute_done, pred           classifier result pulse and predicted label
//   busy, pass_done              status; pass_done pulses after a full pass
//   total_cnt, correct_cnt       saturating scores since start
module hdc_msg_sequencer
  import hdc_pkg::*;
#(
  parameter int unsigned MAX_LENGTH = MAX_LENGTH_DEF,
  parameter int unsigned MSG_NUMS   = 100,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned LABEL_W    = LABEL_W_DEF,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    loop_mode,
  input  logic                    abort,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [MAX_LENGTH*8-1:0] rom_msg,
  input  logic [LEN_W-1:0]        rom_len,
  input  logic [LABEL_W-1:0]      rom_label,
  output logic [MAX_LENGTH*8-1:0] msg,
  output logic [LEN_W-1:0]        length,
  output logic [LABEL_W-1:0]      label,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  input  logic                    compute_done,
  input  logic [LABEL_W-1:0]      pred,
  output logic                    busy,
  output logic                    pass_done,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        correct_cnt
);

  localparam int unsigned MSG_W  = MAX_LENGTH * 8;
  localparam int unsigned LAT_W  = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_NUMS - 1);
  localparam logic [LAT_W-1:0]  LAT_DONE  = LAT_W'(ROM_LAT);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                loop_q, loop_d;
  logic [MSG_W-1:0]    msg_d;
  logic [LEN_W-1:0]    len_d;
  logic [LABEL_W-1:0]  label_d;
  logic                valid_d, busy_d, pass_d;
  logic                cnt_clr_c, tot_inc_c, cor_inc_c;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rom_addr  <= '0;
      lat_q     <= '0;
      loop_q    <= 1'b0;
      msg       <= '0;
      length    <= '0;
      label     <= '0;
      msg_valid <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      rom_addr  <= addr_d;
      lat_q     <= lat_d;
      loop_q    <= loop_d;
      msg       <= msg_d;
      length    <= len_d;
      label     <= label_d;
      msg_valid <= valid_d;
      busy      <= busy_d;
      pass_done <= pass_d;
    end
  end

  // Next-state, datapath and counter control.
  always_comb begin
    state_d   = state_q;
    addr_d    = rom_addr;
    lat_d     = lat_q;
    loop_d    = loop_q;
    msg_d     = msg;
    len_d     = length;
    label_d   = label;
    pass_d    = 1'b0;
    cnt_clr_c = 1'b0;
    tot_inc_c = 1'b0;
    cor_inc_c = 1'b0;

    if ((state_q != IDLE) && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = FETCH;
            addr_d    = '0;
            lat_d     = '0;
            loop_d    = loop_mode;
            cnt_clr_c = 1'b1;
          end
        end
        FETCH: begin
          // Wait out the ROM read latency before sampling the data.
          if (lat_q == LAT_DONE) begin
            msg_d   = rom_msg;
            len_d   = rom_len;
            label_d = rom_label;
            state_d = PRESENT;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        PRESENT: begin
          if (msg_ready) begin
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (compute_done) begin
            tot_inc_c = 1'b1;
            cor_inc_c = (pred == label);
            lat_d     = '0;
            if (rom_addr == LAST_ADDR) begin
              pass_d = 1'b1;
              if (loop_q) begin
                addr_d  = '0;
                state_d = FETCH;
              end else begin
                state_d = IDLE;
              end
            end else begin
              addr_d  = rom_addr + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  hdc_score_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .inc   (tot_inc_c),
    .cnt   (total_cnt)
  );

  hdc_score_counter #(.CNT_W(CNT_W)) u_correct_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .inc   (cor_inc_c),
    .cnt   (correct_cnt)
  );

endmodule

// File: tb/tb_hdc_msg_sequencer.sv
// Self-checking bench: two sequencer instances (A: 3 msgs, ROM latency 3,
// 3-bit scores; B: 4 msgs, ROM latency 1, 16-bit scores) share the classifier
// side inputs and are exercised one at a time against a message-level model.
module tb_hdc_msg_sequencer;

  localparam int unsigned MW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop_mode = 1'b0, abort = 1'b0, msg_ready = 1'b0, compute_done = 1'b0;
  logic [1:0] pred = '0;
  logic a_start = 1'b0, b_start = 1'b0;

  logic [1:0]    a_addr, b_addr;
  logic [MW-1:0] a_rom_msg, b_rom_msg, a_msg, b_msg;
  logic [7:0]    a_rom_len, b_rom_len, a_len, b_len;
  logic [1:0]    a_rom_lab, b_rom_lab, a_lab, b_lab;
  logic          a_valid, b_valid, a_busy, b_busy, a_pass, b_pass;
  logic [2:0]    a_tot, a_cor;
  logic [15:0]   b_tot, b_cor;

  logic [MW-1:0] rom_msg_t [4];
  logic [7:0]    rom_len_t [4];
  logic [1:0]    rom_lab_t [4];

  always #5 clk = ~clk;

  // ROM models: data follows the address after a fixed pipeline delay.
  logic [1:0] a_pipe [3];
  logic [1:0] b_pipe;
  always @(posedge clk) begin
    a_pipe[0] <= a_addr;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    b_pipe    <= b_addr;
  end
  assign a_rom_msg = rom_msg_t[a_pipe[2]];
  assign a_rom_len = rom_len_t[a_pipe[2]];
  assign a_rom_lab = rom_lab_t[a_pipe[2]];
  assign b_rom_msg = rom_msg_t[b_pipe];
  assign b_rom_len = rom_len_t[b_pipe];
  assign b_rom_lab = rom_lab_t[b_pipe];

  hdc_msg_sequencer #(
    .MAX_LENGTH(4), .MSG_NUMS(3), .ADDR_W(2), .LEN_W(8), .LABEL_W(2),
    .ROM_LAT(3), .CNT_W(3)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .loop_mode(loop_mode),
    .abort(abort), .rom_addr(a_addr), .rom_msg(a_rom_msg),
    .rom_len(a_rom_len), .rom_label(a_rom_lab), .msg(a_msg), .length(a_len),
    .label(a_lab), .msg_valid(a_valid), .msg_ready(msg_ready),
    .compute_done(compute_done), .pred(pred), .busy(a_busy),
    .pass_done(a_pass), .total_cnt(a_tot), .correct_cnt(a_cor)
  );

  hdc_msg_sequencer #(
    .MAX_LENGTH(4), .MSG_NUMS(4), .ADDR_W(2), .LEN_W(8), .LABEL_W(2),
    .ROM_LAT(1), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .loop_mode(loop_mode),
    .abort(abort), .rom_addr(b_addr), .rom_msg(b_rom_msg),
    .rom_len(b_rom_len), .rom_label(b_rom_lab), .msg(b_msg), .length(b_len),
    .label(b_lab), .msg_valid(b_valid), .msg_ready(msg_ready),
    .compute_done(compute_done), .pred(pred), .busy(b_busy),
    .pass_done(b_pass), .total_cnt(b_tot), .correct_cnt(b_cor)
  );

  // View of whichever instance is under test.
  bit sel = 1'b0;
  logic [1:0]    o_addr, o_lab;
  logic [MW-1:0] o_msg;
  logic [7:0]    o_len;
  logic          o_valid, o_busy, o_pass;
  logic [15:0]   o_tot, o_cor;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_msg   = sel ? b_msg   : a_msg;
  assign o_len   = sel ? b_len   : a_len;
  assign o_lab   = sel ? b_lab   : a_lab;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_pass  = sel ? b_pass  : a_pass;
  assign o_tot   = sel ? b_tot   : 16'(a_tot);
  assign o_cor   = sel ? b_cor   : 16'(a_cor);

  int obs_pass;
  always @(posedge clk) if (o_pass === 1'b1) obs_pass <= obs_pass + 1;

  int errors = 0;
  int checks = 0;

  // Message-level reference model state.
  int nmsg, lat, cmax, m_k, m_total, m_correct, m_pass, pass_base;
  bit m_loop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > cmax) ? cmax : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel) b_start = v;
    else     a_start = v;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while ((o_valid !== 1'b1) && (cyc < budget)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr",    64'(o_addr),  64'(0));
    chk("rst_msg",     64'(o_msg),   64'(0));
    chk("rst_len",     64'(o_len),   64'(0));
    chk("rst_label",   64'(o_lab),   64'(0));
    chk("rst_valid",   64'(o_valid), 64'(0));
    chk("rst_busy",    64'(o_busy),  64'(0));
    chk("rst_pass",    64'(o_pass),  64'(0));
    chk("rst_total",   64'(o_tot),   64'(0));
    chk("rst_correct", 64'(o_cor),   64'(0));
  endtask

  task automatic start_run(input bit loop);
    int cyc;
    nmsg = sel ? 4 : 3;
    lat  = sel ? 1 : 3;
    cmax = sel ? 65535 : 7;
    m_k = 0; m_total = 0; m_correct = 0; m_pass = 0; m_loop = loop;
    pass_base = obs_pass;
    loop_mode = loop;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    loop_mode = !loop;
    chk("start_busy",    64'(o_busy),  64'(1));
    chk("start_addr",    64'(o_addr),  64'(0));
    chk("start_valid",   64'(o_valid), 64'(0));
    chk("start_total",   64'(o_tot),   64'(0));
    chk("start_correct", 64'(o_cor),   64'(0));
    wait_valid(20, cyc);
    chk("start_lat", 64'(cyc), 64'(lat + 1));
  endtask

  // One message: check payload, apply backpressure, handshake, then score.
  task automatic serve(input int rdy_dly, input bit wrong, input int done_dly,
                       input bit spurious);
    int cyc, idx, exp_cyc;
    bit last;
    idx = m_k % nmsg;
    exp_cyc = (m_k == 0) ? 0 : lat + 1;
    wait_valid(20, cyc);
    chk("valid_seen", 64'(o_valid), 64'(1));
    chk("fetch_lat",  64'(cyc),     64'(exp_cyc));
    chk("pass_low",   64'(o_pass),  64'(0));
    chk("addr",       64'(o_addr),  64'(idx));
    chk("msg",        64'(o_msg),   64'(rom_msg_t[idx]));
    chk("len",        64'(o_len),   64'(rom_len_t[idx]));
    chk("label",      64'(o_lab),   64'(rom_lab_t[idx]));
    for (int i = 0; i < rdy_dly; i++) begin
      if (i == 0 && spurious) begin
        compute_done = 1'b1;
        pred = rom_lab_t[idx];
        set_start(1'b1);
      end
      tick();
      compute_done = 1'b0;
      set_start(1'b0);
      chk("bp_valid", 64'(o_valid), 64'(1));
      chk("bp_msg",   64'(o_msg),   64'(rom_msg_t[idx]));
      chk("bp_len",   64'(o_len),   64'(rom_len_t[idx]));
      chk("bp_addr",  64'(o_addr),  64'(idx));
      chk("bp_total", 64'(o_tot),   64'(sat(m_total)));
    end
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    chk("valid_drop", 64'(o_valid), 64'(0));
    chk("wait_busy",  64'(o_busy),  64'(1));
    repeat (done_dly) tick();
    pred = wrong ? (rom_lab_t[idx] ^ 2'b01) : rom_lab_t[idx];
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    m_k++;
    m_total++;
    if (!wrong) m_correct++;
    last = (idx == nmsg - 1);
    if (last) m_pass++;
    chk("total",     64'(o_tot),  64'(sat(m_total)));
    chk("correct",   64'(o_cor),  64'(sat(m_correct)));
    chk("pass_done", 64'(o_pass), 64'(last));
    chk("busy_next", 64'(o_busy), 64'(!(last && !m_loop)));
    chk("next_addr", 64'(o_addr), 64'(last ? (m_loop ? 0 : idx) : idx + 1));
  endtask

  task automatic chk_pass_count();
    tick();
    chk("pass_count", 64'(obs_pass - pass_base), 64'(m_pass));
  endtask

  task automatic abort_now();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",    64'(o_busy),  64'(0));
    chk("abort_valid",   64'(o_valid), 64'(0));
    chk("abort_pass",    64'(o_pass),  64'(0));
    chk("abort_total",   64'(o_tot),   64'(sat(m_total)));
    chk("abort_correct", 64'(o_cor),   64'(sat(m_correct)));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) begin
      rom_msg_t[i] = MW'($urandom);
      rom_len_t[i] = 8'($urandom_range(1, 4));
      rom_lab_t[i] = 2'($urandom);
    end

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; chk_reset_vals();
    sel = 1'b1; chk_reset_vals();
    rst_n = 1'b1;
    tick();

    // B: single pass, all predictions correct, ROM latency 1.
    sel = 1'b1;
    start_run(1'b0);
    for (int k = 0; k < 4; k++) serve($urandom_range(0, 2), 1'b0, $urandom_range(0, 2), 1'b0);
    chk_pass_count();
    chk("b_idle", 64'(o_busy), 64'(0));

    // A: single pass with backpressure, spurious done/start while presenting.
    sel = 1'b0;
    start_run(1'b0);
    serve(5, 1'b0, 0, 1'b1);
    serve(0, 1'b0, 1, 1'b0);
    serve(2, 1'b0, 0, 1'b0);
    chk_pass_count();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("idle_done_total", 64'(o_tot), 64'(3));

    // A: loop mode, wrong prediction at address 1, then abort in WAIT_DONE.
    start_run(1'b1);
    for (int k = 0; k < 6; k++) serve($urandom_range(0, 2), (k % 3) == 1, $urandom_range(0, 2), 1'b0);
    chk("loop_total",   64'(o_tot), 64'(6));
    chk("loop_correct", 64'(o_cor), 64'(4));
    wait_valid(20, cyc);
    chk("abort_pre_valid", 64'(o_valid), 64'(1));
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    chk("abort_pre_busy", 64'(o_busy), 64'(1));
    abort_now();
    chk_pass_count();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("post_abort_total", 64'(o_tot), 64'(6));

    // A: saturation with every prediction correct.
    start_run(1'b1);
    for (int k = 0; k < 10; k++) serve(0, 1'b0, $urandom_range(0, 1), 1'b0);
    chk("sat_total",   64'(o_tot), 64'(7));
    chk("sat_correct", 64'(o_cor), 64'(7));
    abort_now();

    // A: random scoring, then asynchronous reset while fetching.
    start_run(1'b1);
    for (int k = 0; k < 10; k++)
      serve($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 2), 1'b0);
    chk("rst_pre_busy", 64'(o_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_stays_idle", 64'(o_busy), 64'(0));

    // B: random single pass after reset.
    sel = 1'b1;
    start_run(1'b0);
    for (int k = 0; k < 4; k++)
      serve($urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3), 1'b0);
    chk_pass_count();
    chk("b_final_idle", 64'(o_busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdc_msg_sequencer.md
# hdc_msg_sequencer

Parametrised message sequencer that streams test messages from external message/length/label ROMs into the HDC spam-classifier core. It uses a proper valid/ready handshake and handles configurable ROM read latency. It supports single-pass and continuous-loop modes, and scores the classifier's predictions against the ROM labels. It sits between the ROM bank and the HDC encoder/classifier, and its counters are read by the result/LED logic.

## Interface
Parameters:
- MAX_LENGTH, 200, maximum message length in bytes; message bus is MAX_LENGTH*8 bits
- MSG_NUMS, 100, number of messages in ROM (1..2^ADDR_W)
- ADDR_W, 7, ROM address width
- LEN_W, 8, length field width
- LABEL_W, 2, label/prediction width
- ROM_LAT, 1, ROM read latency in cycles (1..4)
- CNT_W, 16, score counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a run
- loop_mode  in  1  1 = wrap after last message and continue; sampled at start
- abort  in  1  synchronous return to IDLE
- rom_addr  out  ADDR_W  shared address to all three ROMs
- rom_msg  in  MAX_LENGTH*8  message ROM data
- rom_len  in  LEN_W  length ROM data
- rom_label  in  LABEL_W  label ROM data
- msg  out  MAX_LENGTH*8  registered message to classifier
- length  out  LEN_W  registered length
- label  out  LABEL_W  registered label
- msg_valid  out  1  msg/length/label valid
- msg_ready  in  1  classifier accepts message
- compute_done  in  1  one-cycle pulse, classification finished
- pred  in  LABEL_W  predicted label, valid with compute_done
- busy  out  1  state is not IDLE
- pass_done  out  1  one-cycle pulse after the last message of a pass is scored
- total_cnt  out  CNT_W  messages scored since start
- correct_cnt  out  CNT_W  messages with pred == label since start

## Operation
- FSM states: IDLE, FETCH, PRESENT, WAIT_DONE.
- **IDLE:** On start, the block clears the counters, sets rom_addr to 0, latches loop_mode, and goes to FETCH.
- **FETCH:** An internal latency counter runs from 0. When it reaches ROM_LAT, the block captures rom_msg, rom_len and rom_label into msg, length and label, then goes to PRESENT.
- **PRESENT:** msg_valid is 1. On msg_valid && msg_ready, the block goes to WAIT_DONE. msg_valid drops the next cycle. msg/length/label stay stable while valid.
- **WAIT_DONE:** On compute_done:
  - total_cnt increments.
  - correct_cnt increments if pred == label.
  - If rom_addr == MSG_NUMS-1: the block pulses pass_done. If loop_mode was latched, rom_addr becomes 0 and the FSM goes to FETCH. Otherwise the FSM goes to IDLE.
  - Otherwise rom_addr increments and the FSM goes to FETCH.
- Counters saturate at 2^CNT_W-1 and do not wrap. They hold their values in IDLE until the next start.
- start is ignored when not in IDLE. compute_done is ignored outside WAIT_DONE. msg_ready is ignored outside PRESENT.
- abort has priority over all other inputs in every state except IDLE. On abort:
  - the FSM goes to IDLE;
  - msg_valid goes to 0;
  - the counters hold;
  - pass_done is not pulsed.
- **Reset values:** state IDLE, rom_addr 0, msg 0, length 0, label 0, msg_valid 0, busy 0, pass_done 0, total_cnt 0, correct_cnt 0. Asserting reset mid-run returns to these values immediately.

## Timing
- rom_addr is registered and changes on the edge that enters FETCH.
- If start is sampled at edge T, then:
  - rom_addr = 0 from T;
  - the ROM data is captured at edge T+1+ROM_LAT;
  - msg_valid is first high in the cycle after edge T+1+ROM_LAT. For ROM_LAT=1, msg_valid rises at edge T+2.
- Handshake completes on the edge where msg_valid && msg_ready are both 1. If msg_ready is already high, msg_valid is high for exactly one cycle.
- compute_done may arrive in the first cycle of WAIT_DONE. The counter updates appear one edge later.
- pass_done is registered and high for exactly one cycle, on the edge after the final compute_done.
- Message-to-message overhead, excluding classifier time, is ROM_LAT+2 cycles.

## Structure
- hdc_pkg holds:
  - the state enum (IDLE, FETCH, PRESENT, WAIT_DONE);
  - the default LABEL_W;
  - the default MAX_LENGTH, shared with the encoder.
- One sub-module, hdc_score_counter: a CNT_W saturating counter with clear and increment enable. It is instantiated twice, once for total and once for correct.
- ROMs are external. The top level wires rom_addr to the MSG, LENGTH and TAG ROM instances.

## Test plan
- **Single pass:** MSG_NUMS=4, ROM_LAT=1, msg_ready tied 1, pred = label on all messages, loop_mode=0 → 4 valid pulses; rom_addr sequence 0,1,2,3; total_cnt=4, correct_cnt=4; one pass_done; busy drops to 0.
- **Backpressure:** msg_ready held 0 for 5 cycles in PRESENT → msg_valid stays 1; msg and length are stable; there is no compute_done effect until the handshake completes.
- **Scoring and loop:** loop_mode=1, MSG_NUMS=3, pred wrong on address 1 → after 6 compute_done: total_cnt=6, correct_cnt=4, two pass_done pulses, rom_addr wraps from 2 to 0.
- **Latency sweep:** ROM_LAT=3, ROM model delays data by 3 cycles → the captured msg matches the ROM contents; the first msg_valid comes 4 edges after the start edge.
- **Spurious and abort:** compute_done pulsed in PRESENT and start pulsed while busy → both ignored. Abort in WAIT_DONE → IDLE next edge, msg_valid 0, counters unchanged.
- **Reset and saturation:** rst_n asserted in FETCH → all outputs reset asynchronously. CNT_W=3 with 10 correct messages → both counters stick at 7.
